// File: rtl/btn_pkg.sv
// btn_pkg: shared button-conditioner constants and the default button vector type
package btn_pkg;
    localparam int N_BTN_DEF      = 4;
    localparam int DEBOUNCE_SIM   = 4;
    localparam int DEBOUNCE_BOARD = 1_000_000;
    typedef logic [N_BTN_DEF-1:0] btn_vec_t;
endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: one button - two-FF synchroniser, stable-count debouncer, press pulse and toggle bit
module debounce_cell
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM,
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_toggle
);
    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_toggle;
    logic             w_differs;
    logic             w_accept;
    logic             w_press;

    assign w_differs = r_s2 != r_level;
    assign w_accept  = w_differs && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign w_press   = w_accept && r_s2 && !r_level;

    // synchronise the pin, count consecutive differing samples, accept after the full run
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_cnt    <= '0;
            r_level  <= 1'b0;
            r_rise   <= 1'b0;
            r_toggle <= 1'b0;
        end else begin
            r_s1     <= i_raw;
            r_s2     <= r_s1;
            r_cnt    <= (!w_differs || w_accept) ? '0 : r_cnt + CNT_W'(1);
            r_level  <= w_accept ? r_s2 : r_level;
            r_rise   <= w_press;
            r_toggle <= r_toggle ^ w_press;
        end
    end

    assign o_level  = r_level;
    assign o_rise   = r_rise;
    assign o_toggle = r_toggle;
endmodule

// File: rtl/btn_debounce_toggle.sv
// btn_debounce_toggle: per-button debounce, press pulse and press-to-toggle blanking mask
module btn_debounce_toggle
    import btn_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_BTN-1:0] i_btn_raw,
    output logic [N_BTN-1:0] o_btn_level,
    output logic [N_BTN-1:0] o_btn_rise,
    output logic [N_BTN-1:0] o_btn_mask
);
    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_raw    (i_btn_raw[g]),
            .o_level  (o_btn_level[g]),
            .o_rise   (o_btn_rise[g]),
            .o_toggle (o_btn_mask[g])
        );
    end
endmodule

// File: tb/tb_btn_debounce_toggle.sv
// tb_btn_debounce_toggle: directed and random stimulus against a sample-window reference model
module tb_btn_debounce_toggle;
    localparam int N = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_rise;
    logic [N-1:0] btn_mask;

    int n_cmp = 0;
    int n_bad = 0;
    int rises [N];

    logic [N-1:0] hist [$];
    logic [N-1:0] m_lvl  = '0;
    logic [N-1:0] m_rise = '0;
    logic [N-1:0] m_mask = '0;
    logic [N-1:0] snap;

    btn_debounce_toggle #(.N_BTN(N), .DEBOUNCE_CYCLES(D)) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_btn_raw   (btn_raw),
        .o_btn_level (btn_level),
        .o_btn_rise  (btn_rise),
        .o_btn_mask  (btn_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // raw value sampled at edge idx since the last reset; before that the sync chain held 0
    function automatic logic [N-1:0] past(input int idx);
        return (idx < 0) ? '0 : hist[idx];
    endfunction

    // a level is accepted once the D synchronised samples seen at the last D edges all
    // disagree with it; the synchronised sample at edge n is the raw value from edge n-2
    task automatic model_edge();
        int n;
        logic [N-1:0] v;
        logic stable;
        hist.push_back(btn_raw);
        n = hist.size() - 1;
        m_rise = '0;
        for (int b = 0; b < N; b++) begin
            stable = 1'b1;
            for (int j = 2; j <= D + 1; j++) begin
                v = past(n - j);
                if (v[b] == m_lvl[b]) stable = 1'b0;
            end
            if (stable) begin
                m_lvl[b] = ~m_lvl[b];
                if (m_lvl[b]) begin
                    m_rise[b] = 1'b1;
                    m_mask[b] = ~m_mask[b];
                end
            end
        end
    endtask

    task automatic step(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            if (rst_n) model_edge();
            #1;
            chk("level", btn_level, m_lvl);
            chk("rise", btn_rise, m_rise);
            chk("mask", btn_mask, m_mask);
            for (int b = 0; b < N; b++) rises[b] += int'(btn_rise[b]);
        end
    endtask

    task automatic clr_rises();
        for (int b = 0; b < N; b++) rises[b] = 0;
    endtask

    // assert reset between edges, check outputs clear without a clock, then release
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_level", btn_level, 0);
        chk("rst_async_rise", btn_rise, 0);
        chk("rst_async_mask", btn_mask, 0);
        hist.delete();
        m_lvl = '0;
        m_rise = '0;
        m_mask = '0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        clr_rises();
        step(2);
        chk("reset_state", {btn_level, btn_rise, btn_mask}, 0);
        rst_n = 1'b1;

        // reset mid-debounce, then a full acceptance from scratch
        btn_raw = 4'b0001;
        step(3);
        do_reset();
        step(5);
        chk("rst_no_early_level", btn_level[0], 0);
        step(1);
        chk("rst_full_accept", btn_level[0], 1);

        // clean press from a fresh reset
        btn_raw = '0;
        do_reset();
        step(12);
        btn_raw = 4'b0001;
        step(6);
        chk("clean_level", btn_level, 4'b0001);
        chk("clean_rise", btn_rise, 4'b0001);
        step(1);
        chk("clean_rise_off", btn_rise, 0);
        chk("clean_mask", btn_mask, 4'b0001);

        // bounce rejection on button 1
        clr_rises();
        for (int k = 0; k < 4; k++) begin
            btn_raw[1] = (k % 2 == 0);
            step(2);
        end
        chk("bounce_no_rise", rises[1], 0);
        btn_raw[1] = 1'b1;
        step(5);
        chk("bounce_not_yet", btn_rise[1], 0);
        step(1);
        chk("bounce_rise", btn_rise[1], 1);
        step(6);
        chk("bounce_one_rise", rises[1], 1);

        // press/release button 2 twice
        clr_rises();
        btn_raw[2] = 1'b1; step(10);
        chk("tog_mask_1", btn_mask[2], 1);
        btn_raw[2] = 1'b0; step(10);
        chk("tog_mask_hold", btn_mask[2], 1);
        btn_raw[2] = 1'b1; step(10);
        chk("tog_mask_0", btn_mask[2], 0);
        btn_raw[2] = 1'b0; step(10);
        chk("tog_rises", rises[2], 2);

        // simultaneous presses
        btn_raw = '0;
        step(10);
        snap = btn_mask;
        btn_raw = 4'b1010;
        step(6);
        chk("sim_rise", btn_rise, 4'b1010);
        chk("sim_mask", btn_mask, snap ^ 4'b1010);

        // long hold on button 3
        btn_raw = '0;
        step(10);
        clr_rises();
        btn_raw = 4'b1000;
        step(50);
        chk("hold_one_rise", rises[3], 1);
        chk("hold_level", btn_level[3], 1);

        // random bursts of varying length, with an occasional reset
        for (int r = 0; r < 150; r++) begin
            btn_raw = N'($urandom);
            step($urandom_range(1, 8));
            if (r == 75) do_reset();
        end
        btn_raw = '0;
        step(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
